// File: rtl/evm_pkg.sv
// rtl/evm_pkg.sv - shared constants and FSM state type for the ballot capture block
package evm_pkg;

  localparam int NUM_CANDIDATES          = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int DEFAULT_LOCKOUT_CYCLES  = 125000000;

  typedef enum logic [1:0] {
    ST_ARMED,
    ST_EVAL,
    ST_LOCKOUT,
    ST_WAIT_RELEASE
  } vote_state_e;

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - two-flop synchroniser followed by a stable-level debounce counter
module button_debouncer
  import evm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any cycle where the input agrees with the accepted level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign btn_level = level_q;

endmodule

// File: rtl/ballot_capture.sv
// rtl/ballot_capture.sv - four-candidate vote capture: debounced buttons, vote FSM, saturating tallies
module ballot_capture
  import evm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LOCKOUT_CYCLES  = DEFAULT_LOCKOUT_CYCLES,
  parameter int COUNT_W         = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               mode,
  input  logic               button1,
  input  logic               button2,
  input  logic               button3,
  input  logic               button4,
  output logic               valid_vote_casted,
  output logic               invalid_vote,
  output logic [COUNT_W-1:0] candidate1_vote,
  output logic [COUNT_W-1:0] candidate2_vote,
  output logic [COUNT_W-1:0] candidate3_vote,
  output logic [COUNT_W-1:0] candidate4_vote,
  output logic               candidate1_button_press,
  output logic               candidate2_button_press,
  output logic               candidate3_button_press,
  output logic               candidate4_button_press,
  output logic               busy
);

  localparam int                 LOCK_W    = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [COUNT_W-1:0] TALLY_MAX = '1;

  // Reset asserts asynchronously but releases only after two clean clock edges.
  logic rst_meta_q;
  logic rst_sync_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  logic [NUM_CANDIDATES-1:0] btn_raw;
  logic [NUM_CANDIDATES-1:0] deb;

  assign btn_raw = {button4, button3, button2, button1};

  for (genvar g = 0; g < NUM_CANDIDATES; g++) begin : g_deb
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clock    (clock),
      .rst_n    (rst_sync_q),
      .btn_raw  (btn_raw[g]),
      .btn_level(deb[g])
    );
  end

  vote_state_e               state_q;
  vote_state_e               state_d;
  logic [NUM_CANDIDATES-1:0] deb_prev_q;
  logic [LOCK_W-1:0]         lock_cnt_q;
  logic [LOCK_W-1:0]         lock_cnt_d;
  logic [COUNT_W-1:0]        tally_q [NUM_CANDIDATES];
  logic [COUNT_W-1:0]        tally_d [NUM_CANDIDATES];
  logic                      valid_q;
  logic                      valid_d;
  logic                      invalid_q;
  logic                      invalid_d;
  logic                      one_hot;

  assign one_hot = (deb != '0) && ((deb & (deb - 1'b1)) == '0);

  always_ff @(posedge clock or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q    <= ST_ARMED;
      deb_prev_q <= '0;
      lock_cnt_q <= '0;
      valid_q    <= 1'b0;
      invalid_q  <= 1'b0;
      for (int i = 0; i < NUM_CANDIDATES; i++) tally_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      deb_prev_q <= deb;
      lock_cnt_q <= lock_cnt_d;
      valid_q    <= valid_d;
      invalid_q  <= invalid_d;
      for (int i = 0; i < NUM_CANDIDATES; i++) tally_q[i] <= tally_d[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    valid_d    = 1'b0;
    invalid_d  = 1'b0;
    for (int i = 0; i < NUM_CANDIDATES; i++) tally_d[i] = tally_q[i];
    case (state_q)
      ST_ARMED: begin
        if (!mode && ((deb & ~deb_prev_q) != '0)) state_d = ST_EVAL;
      end
      // The decision is taken regardless of mode so a vote already started completes.
      ST_EVAL: begin
        if (one_hot) begin
          valid_d    = 1'b1;
          lock_cnt_d = '0;
          state_d    = ST_LOCKOUT;
          for (int i = 0; i < NUM_CANDIDATES; i++) begin
            if (deb[i] && (tally_q[i] != TALLY_MAX)) tally_d[i] = tally_q[i] + COUNT_W'(1);
          end
        end else begin
          invalid_d = (deb != '0);
          state_d   = ST_WAIT_RELEASE;
        end
      end
      ST_LOCKOUT: begin
        if (lock_cnt_q == LOCK_W'(LOCKOUT_CYCLES - 1)) state_d = ST_WAIT_RELEASE;
        else lock_cnt_d = lock_cnt_q + LOCK_W'(1);
      end
      ST_WAIT_RELEASE: begin
        if (deb == '0) state_d = ST_ARMED;
      end
      default: state_d = ST_ARMED;
    endcase
  end

  assign valid_vote_casted       = valid_q;
  assign invalid_vote            = invalid_q;
  assign busy                    = (state_q != ST_ARMED);
  assign candidate1_vote         = tally_q[0];
  assign candidate2_vote         = tally_q[1];
  assign candidate3_vote         = tally_q[2];
  assign candidate4_vote         = tally_q[3];
  assign candidate1_button_press = deb[0];
  assign candidate2_button_press = deb[1];
  assign candidate3_button_press = deb[2];
  assign candidate4_button_press = deb[3];

endmodule

// File: doc/ballot_capture.md
BALLOT_CAPTURE -- requirements
Module: ballot_capture

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, stable-level cycles required before a button change is accepted.
REQ-002 Parameter LOCKOUT_CYCLES, default 125000000, minimum cycles after an accepted vote before the next vote is armed.
REQ-003 Parameter COUNT_W, default 4, width of each per-candidate tally.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 clock  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 mode  in  1  0 = voting, 1 = result.
REQ-008 button1..button4  in  1 each  raw, unsynchronised candidate push-buttons.
REQ-009 valid_vote_casted  out  1  one-cycle pulse per accepted vote.
REQ-010 invalid_vote  out  1  one-cycle pulse per rejected multi-button press.
REQ-011 candidate1_vote..candidate4_vote  out  COUNT_W each  per-candidate tallies.
REQ-012 candidate1_button_press..candidate4_button_press  out  1 each  debounced button levels.
REQ-013 busy  out  1  high in every FSM state except ARMED.

Function
REQ-014 Each button SHALL pass through a 2-flop synchroniser, then a debouncer; the debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-015 candidateN_button_press SHALL equal the debounced level of buttonN in both modes.
REQ-016 FSM states: ARMED, EVAL, LOCKOUT, WAIT_RELEASE; reset state ARMED.
REQ-017 ARMED: on any debounced rising edge while mode=0 -> EVAL next cycle; while mode=1, no transition.
REQ-018 EVAL (one cycle): exactly one debounced level high -> increment that tally, pulse valid_vote_casted, -> LOCKOUT; two or more high -> pulse invalid_vote, no tally change, -> WAIT_RELEASE.
REQ-019 Pulses SHALL be asserted in the cycle the FSM leaves EVAL; latency from debounced rising edge to pulse is 2 cycles.
REQ-020 LOCKOUT: count LOCKOUT_CYCLES cycles, then -> WAIT_RELEASE; presses during LOCKOUT are ignored.
REQ-021 WAIT_RELEASE: -> ARMED in the cycle after all four debounced levels are low.
REQ-022 Tallies SHALL saturate at 2^COUNT_W-1; a vote at saturation still pulses valid_vote_casted but leaves the tally unchanged.
REQ-023 Tallies SHALL NOT change in mode=1; mode switching to 1 mid-EVAL SHALL still complete the EVAL decision.
REQ-024 A rising edge on one button while another is already held SHALL be evaluated as a multi-press (invalid).
REQ-025 Lockout counter width SHALL be clog2(LOCKOUT_CYCLES+1); it SHALL be cleared on every entry to LOCKOUT.

Reset
REQ-026 Asserting reset low SHALL immediately clear tallies, pulses, debounced levels, synchronisers, and counters, and force FSM to ARMED, including mid-LOCKOUT or mid-EVAL.
REQ-027 Reset values: valid_vote_casted=0, invalid_vote=0, all tallies=0, all button_press=0, busy=0.
REQ-028 Deassertion SHALL be synchronised to clock by a 2-flop reset synchroniser before release.

Structure
REQ-029 FSM state enum, NUM_CANDIDATES=4, and the default DEBOUNCE_CYCLES/LOCKOUT_CYCLES constants SHALL live in shared package evm_pkg.
REQ-030 One sub-module, button_debouncer (synchroniser + debounce counter, parameter DEBOUNCE_CYCLES), instantiated four times.

Verification (DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8, COUNT_W=4)
REQ-031 mode=0, button2 held 20 cycles -> single valid_vote_casted pulse, candidate2_vote 0->1, busy high through LOCKOUT and until release.
REQ-032 button1 toggling every 2 cycles for 30 cycles -> no debounced edge, no pulse, tallies unchanged.
REQ-033 button1 and button3 pressed together -> invalid_vote pulse, all tallies unchanged, next single press counted only after both released.
REQ-034 17 valid votes for candidate4 -> candidate4_vote stops at 15, 17 valid pulses.
REQ-035 mode=1, button3 pressed -> candidate3_button_press high after debounce, no tally change, no pulses.
REQ-036 reset driven low during LOCKOUT -> all tallies 0 immediately, FSM ARMED after release, next press counted normally.
